// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared defaults and one-hot select decode function for the stream router
package demux_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_N_CH   = 8;
  localparam int MAX_CH         = 64;
  localparam int MAX_SEL_W      = 7;

  // Mask is sized for the largest channel count; callers keep the low n bits.
  // An out-of-range select yields an all-zero mask, never a phantom channel bit.
  function automatic logic [MAX_CH-1:0] onehot_dec(input logic [MAX_SEL_W-1:0] sel,
                                                   input int unsigned n);
    logic [MAX_CH-1:0] mask;
    mask = '0;
    if ({25'd0, sel} < n) begin
      mask[sel[5:0]] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - parametrised select-to-one-hot decoder with range check
module onehot_decoder
  import demux_pkg::*;
#(
  parameter int N_OUT = DEFAULT_N_CH,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [N_OUT-1:0] o_mask,
  output logic             o_in_range
);

  logic [MAX_CH-1:0]    w_mask_full;
  logic [MAX_SEL_W-1:0] w_sel_ext;

  assign w_sel_ext   = MAX_SEL_W'(i_sel);
  assign w_mask_full = onehot_dec(w_sel_ext, N_OUT);
  assign o_mask      = w_mask_full[N_OUT-1:0];
  // A legal select always sets exactly one bit, so an empty mask means out of range.
  assign o_in_range  = |w_mask_full;

endmodule

// File: rtl/demux_stream_router.sv
// rtl/demux_stream_router.sv - registered valid/ready demux to N_CH channels; optional DEMUX_ROUTER_ERR_EN illegal-select capture
module demux_stream_router
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N_CH   = DEFAULT_N_CH,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  input  logic [DATA_W-1:0] in_data,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err,
  output logic [SEL_W-1:0]  err_sel
);

  logic [N_CH-1:0]   r_pend;
  logic [DATA_W-1:0] r_data;
  logic [N_CH-1:0]   w_rem;
  logic [N_CH-1:0]   w_dec_mask;
  logic              w_in_range;
  logic              w_accept;
  logic              w_illegal;

  onehot_decoder #(
    .N_OUT (N_CH),
    .SEL_W (SEL_W)
  ) u_dec (
    .i_sel      (in_sel),
    .o_mask     (w_dec_mask),
    .o_in_range (w_in_range)
  );

  // Channels still owed after this cycle's handshakes; any leftover blocks a new load.
  assign w_rem     = r_pend & ~out_ready;
  assign in_ready  = ~|w_rem;
  assign w_accept  = in_valid & in_ready;
  assign w_illegal = ~in_bcast & ~w_in_range;

  // Load a fresh mask on accept (replacing the finishing one without a bubble), else retire delivered channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_pend <= in_bcast ? '1 : w_dec_mask;
      if (!w_illegal) begin
        r_data <= in_data;
      end
    end else begin
      r_pend <= w_rem;
    end
  end

  assign out_valid = r_pend;
  assign out_data  = r_data;
  assign busy      = |r_pend;

`ifdef DEMUX_ROUTER_ERR_EN
  logic             r_err;
  logic [SEL_W-1:0] r_err_sel;

  // Sticky flag; the select is captured from the first offence only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_sel <= '0;
    end else if (w_accept && w_illegal && !r_err) begin
      r_err     <= 1'b1;
      r_err_sel <= in_sel;
    end
  end

  assign err     = r_err;
  assign err_sel = r_err_sel;
`else
  assign err     = 1'b0;
  assign err_sel = '0;
`endif

endmodule

// File: tb/tb_demux_stream_router.sv
// tb/tb_demux_stream_router.sv - directed bench for demux_stream_router at N_CH=8 and N_CH=6 (DEMUX_ROUTER_ERR_EN aware)
module tb_demux_stream_router;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_in_bcast, a_busy, a_err;
  logic [2:0] a_in_sel, a_err_sel;
  logic [7:0] a_in_data, a_out_valid, a_out_ready, a_out_data;

  logic       b_in_valid, b_in_ready, b_in_bcast, b_busy, b_err;
  logic [2:0] b_in_sel, b_err_sel;
  logic [7:0] b_in_data, b_out_data;
  logic [5:0] b_out_valid, b_out_ready;

  int n_cmp;
  int n_err;

  demux_stream_router #(.DATA_W(8), .N_CH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_sel    (a_in_sel),
    .in_bcast  (a_in_bcast),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .busy      (a_busy),
    .err       (a_err),
    .err_sel   (a_err_sel)
  );

  demux_stream_router #(.DATA_W(8), .N_CH(6)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_sel    (b_in_sel),
    .in_bcast  (b_in_bcast),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .busy      (b_busy),
    .err       (b_err),
    .err_sel   (b_err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_err;
    logic [2:0] exp_err_sel;
    n_cmp = 0;
    n_err = 0;
`ifdef DEMUX_ROUTER_ERR_EN
    exp_err     = 1'b1;
    exp_err_sel = 3'd7;
`else
    exp_err     = 1'b0;
    exp_err_sel = 3'd0;
`endif

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_sel = 3'd0; a_in_bcast = 1'b0; a_in_data = 8'h00; a_out_ready = 8'h00;
    b_in_valid = 1'b0; b_in_sel = 3'd0; b_in_bcast = 1'b0; b_in_data = 8'h00; b_out_ready = 6'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset / idle
    check("rst_out_valid", 64'(a_out_valid), 64'h00);
    check("rst_busy",      64'(a_busy),      64'h0);
    check("rst_in_ready",  64'(a_in_ready),  64'h1);
    check("rst_out_data",  64'(a_out_data),  64'h00);
    check("rst_err",       64'(b_err),       64'h0);
    check("rst_err_sel",   64'(b_err_sel),   64'h0);

    // Unicast sweep, one transfer per cycle
    a_out_ready = 8'hFF;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_sel  = 3'(i);
      a_in_data = 8'h10 + 8'(i);
      #1;
      check($sformatf("sweep_in_ready_%0d", i), 64'(a_in_ready), 64'h1);
      tick();
      check($sformatf("sweep_out_valid_%0d", i), 64'(a_out_valid), 64'(1) << i);
      check($sformatf("sweep_out_data_%0d", i),  64'(a_out_data),  64'h10 + 64'(i));
    end
    a_in_valid = 1'b0;
    tick();
    check("sweep_drain_busy", 64'(a_busy), 64'h0);

    // Backpressure on channel 5
    a_out_ready = 8'h00;
    a_in_valid  = 1'b1;
    a_in_sel    = 3'd5;
    a_in_data   = 8'hA5;
    tick();
    a_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp_out_valid_%0d", c), 64'(a_out_valid), 64'h20);
      check($sformatf("bp_in_ready_%0d", c),  64'(a_in_ready),  64'h0);
      check($sformatf("bp_out_data_%0d", c),  64'(a_out_data),  64'hA5);
      if (c < 3) tick();
    end
    a_out_ready = 8'h20;
    #1;
    check("bp_release_in_ready", 64'(a_in_ready), 64'h1);
    tick();
    check("bp_done_out_valid", 64'(a_out_valid), 64'h00);
    check("bp_done_busy",      64'(a_busy),      64'h0);

    // Broadcast with partial accepts, next transaction loads as it completes
    a_out_ready = 8'h00;
    a_in_valid  = 1'b1;
    a_in_bcast  = 1'b1;
    a_in_sel    = 3'd3;
    a_in_data   = 8'h3C;
    tick();
    check("bc_out_valid_all", 64'(a_out_valid), 64'hFF);
    check("bc_out_data",      64'(a_out_data),  64'h3C);
    a_in_valid  = 1'b0;
    a_in_bcast  = 1'b0;
    a_out_ready = 8'h0F;
    #1;
    check("bc_partial_in_ready", 64'(a_in_ready), 64'h0);
    tick();
    check("bc_out_valid_rem", 64'(a_out_valid), 64'hF0);
    a_out_ready = 8'hF0;
    a_in_valid  = 1'b1;
    a_in_sel    = 3'd2;
    a_in_data   = 8'h5A;
    #1;
    check("bc_last_in_ready", 64'(a_in_ready), 64'h1);
    tick();
    check("bc_next_out_valid", 64'(a_out_valid), 64'h04);
    check("bc_next_out_data",  64'(a_out_data),  64'h5A);
    a_in_valid  = 1'b0;
    a_out_ready = 8'hFF;
    tick();
    check("bc_next_done_busy", 64'(a_busy), 64'h0);

    // Illegal selects on the six-channel instance
    b_out_ready = 6'h3F;
    b_in_valid  = 1'b1;
    b_in_sel    = 3'd2;
    b_in_data   = 8'h77;
    tick();
    check("ill_pre_out_valid", 64'(b_out_valid), 64'h04);
    check("ill_pre_out_data",  64'(b_out_data),  64'h77);
    b_in_sel  = 3'd7;
    b_in_data = 8'h11;
    #1;
    check("ill_in_ready", 64'(b_in_ready), 64'h1);
    tick();
    check("ill7_out_valid", 64'(b_out_valid), 64'h00);
    check("ill7_out_data",  64'(b_out_data),  64'h77);
    check("ill7_busy",      64'(b_busy),      64'h0);
    check("ill7_err",       64'(b_err),       64'(exp_err));
    check("ill7_err_sel",   64'(b_err_sel),   64'(exp_err_sel));
    b_in_sel  = 3'd6;
    b_in_data = 8'h22;
    tick();
    check("ill6_out_valid", 64'(b_out_valid), 64'h00);
    check("ill6_out_data",  64'(b_out_data),  64'h77);
    check("ill6_err",       64'(b_err),       64'(exp_err));
    check("ill6_err_sel",   64'(b_err_sel),   64'(exp_err_sel));
    b_in_bcast  = 1'b1;
    b_in_sel    = 3'd7;
    b_in_data   = 8'h99;
    b_out_ready = 6'h00;
    tick();
    b_in_valid = 1'b0;
    b_in_bcast = 1'b0;
    check("bc6_out_valid", 64'(b_out_valid), 64'h3F);
    check("bc6_out_data",  64'(b_out_data),  64'h99);
    check("bc6_err_sel",   64'(b_err_sel),   64'(exp_err_sel));

    // Asynchronous reset while a broadcast is held
    a_out_ready = 8'h00;
    a_in_valid  = 1'b1;
    a_in_bcast  = 1'b1;
    a_in_data   = 8'hC3;
    tick();
    a_in_valid = 1'b0;
    a_in_bcast = 1'b0;
    check("arst_pre_out_valid", 64'(a_out_valid), 64'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(a_out_valid), 64'h00);
    check("arst_busy",      64'(a_busy),      64'h0);
    check("arst_out_data",  64'(a_out_data),  64'h00);
    check("arst_b_valid",   64'(b_out_valid), 64'h00);
    check("arst_b_err",     64'(b_err),       64'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check("arst_no_replay_valid", 64'(a_out_valid), 64'h00);
    check("arst_in_ready",        64'(a_in_ready),  64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
